// File: rtl/clk_div_gen.sv
// clk_div_gen: multi-channel clock divider and clock-enable generator.
// Each channel counts a phase 0..N-1 at its runtime-loadable ratio N and
// emits a registered divided clock plus a one-cycle strobe at phase 0.
// A two-state lock FSM reports when outputs have settled after start or
// after a ratio reload.
module clk_div_gen #(
  parameter int NUM_CH      = 3,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 2,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*DIV_W-1:0] div_in,
  input  logic                    div_load,
  input  logic [NUM_CH-1:0]       ch_en,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       clk_en,
  output logic                    locked,
  output logic                    cfg_err
);

  localparam int LCW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  // Ratios below 2 cannot produce a clock; they are forced to 2.
  function automatic logic [DIV_W-1:0] clamp_ratio(input logic [DIV_W-1:0] r);
    return (r < DIV_W'(2)) ? DIV_W'(2) : r;
  endfunction

  // ceil(n/2) with one extra bit so n = 2^DIV_W-1 does not wrap.
  function automatic logic [DIV_W:0] half_ceil(input logic [DIV_W-1:0] n);
    logic [DIV_W:0] sum;
    sum = {1'b0, n} + {{DIV_W{1'b0}}, 1'b1};
    return sum >> 1;
  endfunction

  logic [DIV_W-1:0] ratio [NUM_CH];
  logic [DIV_W-1:0] phase [NUM_CH];
  logic             any_clamp;

  lock_state_t      state_q, state_d;
  logic [LCW-1:0]   lcnt_q, lcnt_d;
  logic             locked_d;

  // Flag whether any ratio presented on div_in would need clamping.
  always_comb begin
    any_clamp = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (div_in[k*DIV_W +: DIV_W] < DIV_W'(2)) any_clamp = 1'b1;
    end
  end

  // Ratio storage, phase counters and registered channel outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        ratio[k] <= DIV_W'(DEFAULT_DIV);
        phase[k] <= '0;
      end
      clk_out <= '0;
      clk_en  <= '0;
      cfg_err <= 1'b0;
    end else if (div_load) begin
      // Every channel restarts so all come back phase-aligned.
      for (int k = 0; k < NUM_CH; k++) begin
        ratio[k] <= clamp_ratio(div_in[k*DIV_W +: DIV_W]);
        phase[k] <= '0;
      end
      clk_out <= '0;
      clk_en  <= '0;
      if (any_clamp) cfg_err <= 1'b1;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_en[k]) begin
          clk_en[k]  <= (phase[k] == '0);
          clk_out[k] <= ({1'b0, phase[k]} < half_ceil(ratio[k]));
          if (phase[k] >= ratio[k] - DIV_W'(1)) phase[k] <= '0;
          else                                  phase[k] <= phase[k] + DIV_W'(1);
        end else begin
          phase[k]   <= '0;
          clk_en[k]  <= 1'b0;
          clk_out[k] <= 1'b0;
        end
      end
    end
  end

  // Lock FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SETTLE;
      lcnt_q  <= '0;
      locked  <= 1'b0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      locked  <= locked_d;
    end
  end

  // Lock FSM next state: count settle edges, restart on any reload.
  always_comb begin
    state_d  = state_q;
    lcnt_d   = lcnt_q;
    locked_d = 1'b0;
    if (div_load) begin
      state_d  = SETTLE;
      lcnt_d   = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        SETTLE: begin
          if (lcnt_q == LCW'(LOCK_CYCLES - 1)) begin
            state_d  = LOCKED;
            lcnt_d   = LCW'(LOCK_CYCLES);
            locked_d = 1'b1;
          end else begin
            lcnt_d = lcnt_q + LCW'(1);
          end
        end
        LOCKED: locked_d = 1'b1;
        default: begin
          state_d  = SETTLE;
          lcnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: directed scenarios plus random
// traffic compared every cycle against an arithmetic reference model.
module tb_clk_div_gen;

  localparam int NCH = 3;
  localparam int DW  = 16;
  localparam int LC  = 16;

  logic              clk;
  logic              reset;
  logic [NCH*DW-1:0] div_in;
  logic              div_load;
  logic [NCH-1:0]    ch_en;
  logic [NCH-1:0]    clk_out;
  logic [NCH-1:0]    clk_en;
  logic              locked;
  logic              cfg_err;

  // Narrow instance for the wide-ratio / small-width corner.
  logic        rst_b;
  logic [3:0]  div_in_b;
  logic        div_load_b;
  logic [0:0]  ch_en_b;
  logic [0:0]  clk_out_b;
  logic [0:0]  clk_en_b;
  logic        locked_b;
  logic        cfg_err_b;

  int checks   = 0;
  int failures = 0;

  clk_div_gen #(.NUM_CH(NCH), .DIV_W(DW), .DEFAULT_DIV(2), .LOCK_CYCLES(LC)) dut (
    .clk(clk), .reset(reset), .div_in(div_in), .div_load(div_load),
    .ch_en(ch_en), .clk_out(clk_out), .clk_en(clk_en),
    .locked(locked), .cfg_err(cfg_err)
  );

  clk_div_gen #(.NUM_CH(1), .DIV_W(4), .DEFAULT_DIV(2), .LOCK_CYCLES(LC)) dut_b (
    .clk(clk), .reset(rst_b), .div_in(div_in_b), .div_load(div_load_b),
    .ch_en(ch_en_b), .clk_out(clk_out_b), .clk_en(clk_en_b),
    .locked(locked_b), .cfg_err(cfg_err_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per channel, count enabled edges since the last
  // restart; the phase is that count modulo the ratio.
  int             m_cnt [NCH];
  int             m_n   [NCH];
  int             since;
  logic [NCH-1:0] exp_out, exp_en;
  logic           exp_locked, exp_cfg;
  bit             mvalid = 0;

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) begin m_cnt[k] = 0; m_n[k] = 2; end
      exp_out = '0; exp_en = '0; exp_cfg = 1'b0; since = 0;
      mvalid = 1;
    end else if (div_load) begin
      for (int k = 0; k < NCH; k++) begin
        int v;
        v = int'(div_in[k*DW +: DW]);
        if (v < 2) begin v = 2; exp_cfg = 1'b1; end
        m_n[k] = v; m_cnt[k] = 0;
      end
      exp_out = '0; exp_en = '0; since = 0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (ch_en[k]) begin
          int p;
          p = m_cnt[k] % m_n[k];
          exp_en[k]  = (p == 0);
          exp_out[k] = (p < (m_n[k] + 1) / 2);
          m_cnt[k]++;
        end else begin
          m_cnt[k] = 0; exp_out[k] = 1'b0; exp_en[k] = 1'b0;
        end
      end
      if (since < 100000) since++;
    end
    exp_locked = (since >= LC);
  end

  // Compare process: outputs against the model every cycle.
  always @(negedge clk) begin
    if (mvalid) begin
      check("model_clk_out", 32'(clk_out), 32'(exp_out));
      check("model_clk_en",  32'(clk_en),  32'(exp_en));
      check("model_locked",  32'(locked),  32'(exp_locked));
      check("model_cfg_err", 32'(cfg_err), 32'(exp_cfg));
    end
  end

  task automatic load(input int r0, input int r1, input int r2);
    @(negedge clk);
    div_in   = {DW'(r2), DW'(r1), DW'(r0)};
    div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; div_load = 1'b0; div_in = '0; ch_en = '1;
    rst_b = 1'b1; div_load_b = 1'b0; div_in_b = '0; ch_en_b = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0; rst_b = 1'b0;

    // Defaults: ratio 2 on every channel.
    @(negedge clk);
    check("def_e1_out", 32'(clk_out), 32'h7);
    check("def_e1_en",  32'(clk_en),  32'h7);
    @(negedge clk);
    check("def_e2_out", 32'(clk_out), 32'h0);
    check("def_e2_en",  32'(clk_en),  32'h0);
    @(negedge clk);
    check("def_e3_en",  32'(clk_en),  32'h7);
    repeat (12) @(negedge clk);
    check("def_e15_locked", 32'(locked), 32'h0);
    @(negedge clk);
    check("def_e16_locked", 32'(locked), 32'h1);

    // Ratios {3,4,7}.
    load(3, 4, 7);
    check("ld_edge_out",    32'(clk_out), 32'h0);
    check("ld_edge_locked", 32'(locked),  32'h0);
    @(negedge clk);
    check("ld_e1_out", 32'(clk_out), 32'h7);
    check("ld_e1_en",  32'(clk_en),  32'h7);
    repeat (2) @(negedge clk);
    check("ld_e3_out", 32'(clk_out), 32'h4);
    @(negedge clk);
    check("ld_e4_out", 32'(clk_out), 32'h5);
    check("ld_e4_en",  32'(clk_en),  32'h1);
    repeat (11) @(negedge clk);
    check("ld_e15_locked", 32'(locked), 32'h0);
    @(negedge clk);
    check("ld_e16_locked", 32'(locked), 32'h1);

    // Clamped ratios 0 and 1 behave as 2; cfg_err is sticky.
    load(5, 0, 1);
    check("clamp_cfg_err", 32'(cfg_err), 32'h1);
    @(negedge clk);
    check("clamp_e1_out", 32'(clk_out), 32'h7);
    @(negedge clk);
    check("clamp_e2_out", 32'(clk_out), 32'h1);
    load(3, 4, 7);
    repeat (3) @(negedge clk);
    check("clamp_sticky", 32'(cfg_err), 32'h1);

    // Ratio 5, drop ch_en[0] at p=3 for 4 edges.
    load(5, 5, 5);
    repeat (4) @(negedge clk);
    ch_en = 3'b110;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("dis_out0", 32'(clk_out[0]), 32'h0);
      check("dis_en0",  32'(clk_en[0]),  32'h0);
    end
    ch_en = 3'b111;
    @(negedge clk);
    check("reen_out", 32'(clk_out), 32'h1);
    check("reen_en",  32'(clk_en),  32'h1);

    // Reset together with a load: reset wins.
    @(negedge clk);
    reset = 1'b1; div_load = 1'b1; div_in = {DW'(9), DW'(0), DW'(6)};
    @(negedge clk);
    reset = 1'b0; div_load = 1'b0;
    check("rst_out",     32'(clk_out), 32'h0);
    check("rst_en",      32'(clk_en),  32'h0);
    check("rst_locked",  32'(locked),  32'h0);
    check("rst_cfg_err", 32'(cfg_err), 32'h0);
    @(negedge clk);
    check("rst_e1_out", 32'(clk_out), 32'h7);
    @(negedge clk);
    check("rst_e2_out", 32'(clk_out), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset    = ($urandom_range(0, 299) == 0);
      div_load = ($urandom_range(0, 39) == 0);
      for (int k = 0; k < NCH; k++) begin
        div_in[k*DW +: DW] = DW'($urandom_range(0, 9));
        if ($urandom_range(0, 15) == 0) ch_en[k] = ~ch_en[k];
      end
    end
    @(negedge clk);
    reset = 1'b0; div_load = 1'b0;

    // Narrow instance: ratio 15 in a 4-bit field.
    @(negedge clk);
    div_in_b = 4'hF; div_load_b = 1'b1;
    @(negedge clk);
    div_load_b = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("w4_out", 32'(clk_out_b), ((i % 15) < 8) ? 32'h1 : 32'h0);
      check("w4_en",  32'(clk_en_b),  ((i % 15) == 0) ? 32'h1 : 32'h0);
    end
    check("w4_cfg_err", 32'(cfg_err_b), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
- Synthesizable, parametrised multi-channel clock-divider and clock-enable generator.
- Successor to the fixed three-output vendor clock wizard, intended for logic-generated slow clocks, e.g. processor step clock, display refresh and debounce tick.
- Derives NUM_CH divided clocks and matching one-cycle enable strobes from the single system clock.
- Supports runtime-loadable divide ratios, per-channel enables and a lock indicator with programmable settle time.

Parameters:
NUM_CH, 3, number of output channels
DIV_W, 16, width of each channel's divide ratio
DEFAULT_DIV, 2, ratio loaded into every channel at reset (must be >= 2)
LOCK_CYCLES, 16, clk edges from start/restart until locked asserts (>= 1)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
div_in  in  NUM_CH*DIV_W  channel k ratio at bits [k*DIV_W +: DIV_W]
div_load  in  1  single-cycle strobe: latch div_in into all channel ratios
ch_en  in  NUM_CH  per-channel run enable
clk_out  out  NUM_CH  divided clocks, registered
clk_en  out  NUM_CH  one-cycle strobe at each clk_out rising phase, registered
locked  out  1  outputs stable at configured ratios
cfg_err  out  1  sticky: a ratio < 2 was loaded and clamped

Behaviour:
- Clock and reset: one clock domain. reset is synchronous and active-high; it wins over all other inputs on the same edge.
- Reset values:
  - clk_out=0, clk_en=0, locked=0, cfg_err=0
  - all ratios = DEFAULT_DIV
  - all phase counters = 0
  - lock FSM in SETTLE with its counter at 0
- Per-channel phase counter (width DIV_W):
  - For an enabled channel with ratio N, phase p runs 0..N-1 and wraps to 0.
  - Edge 1 after reset release, or after a restart, produces p=0.
  - After each edge: clk_en[k]=1 iff p==0; clk_out[k]=1 iff p < ceil(N/2).
  - Even N gives 50% duty. Odd N is high for one extra cycle, e.g. N=3 gives 1,1,0.
- Ratio load:
  - div_load=1 on an edge (reset low) latches all NUM_CH ratios.
  - Any ratio value 0 or 1 is stored as 2 and sets cfg_err; cfg_err clears only on reset.
  - On the load edge, every channel restarts: the next edge is p=0 on all enabled channels, so channels are phase-aligned.
  - Outputs on the load edge itself: clk_out=0, clk_en=0.
- ch_en[k]=0:
  - Channel k counter held at 0; clk_out[k]=0, clk_en[k]=0 from the following edge onward.
  - On re-enable, the first edge with ch_en[k]=1 produces p=0.
  - A disabled channel does not affect locked.
- Lock FSM, two states:
  - SETTLE: counter increments each edge; locked=0. On the edge where the count reaches LOCK_CYCLES, move to LOCKED and set locked=1 (registered on that edge).
  - LOCKED: locked=1.
  - Any div_load: go to SETTLE, counter=0, locked=0 from the load edge onward.
  - div_load while already in SETTLE restarts the count.
  - reset: SETTLE, counter=0.
- Simultaneous events:
  - reset together with div_load: reset wins and the load is discarded.
  - div_load together with ch_en toggles: the ratio is latched and the ch_en value applies from the next edge.
- Arithmetic:
  - Phase compare is unsigned DIV_W-bit.
  - ceil(N/2) = (N+1)>>1, computed in DIV_W+1 bits to avoid overflow at N = 2^DIV_W-1.
- Latency: clk_out and clk_en are registered, one edge after the phase they represent. There is no combinational path from any input to any output.

Test Plan:
- Reset then defaults (DEFAULT_DIV=2, ch_en=all 1) -> clk_out on all channels toggles 1,0,1,0 starting at edge 1; clk_en=1 on edges 1,3,5; locked=1 at edge 16 and not before.
- Load ratios {3,4,7} on channels {0,1,2} -> after the load edge, ch0 clk_out = 1,1,0 repeating; ch1 = 1,1,0,0; ch2 = 1,1,1,1,0,0,0. All clk_en pulse together on the first post-load edge. locked drops on the load edge and re-asserts 16 edges later.
- Load ratio 0 on ch1 and 1 on ch2 -> both behave as ratio 2; cfg_err=1 and stays 1 through later valid loads until reset.
- With ratio 5, drop ch_en[0] mid-period at p=3 for 4 edges, then raise it -> clk_out[0]=0 and clk_en[0]=0 while disabled; first enabled edge gives clk_en[0]=1 and clk_out[0]=1. Other channels are unaffected.
- Assert reset for 1 edge mid-operation with a div_load on the same edge -> all outputs 0, ratios back to 2, cfg_err=0, locked=0; the edge 1 pattern then matches the first scenario.
- DIV_W=4 with ratio 15 -> clk_out high for p=0..7 and low for p=8..14; clk_en every 15 edges; no wrap error.
